uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- UART receiver that recovers 8N1 frames from the serial line driven by the UART transmitter (TX end), at a selectable baud rate.
- Mid-bit sampling with 3-sample majority vote, start-bit glitch rejection and stop-bit framing check.
- Delivers each good byte with a one-cycle done strobe.
- Sits inside UART_Top as the RX path, facing the far end's Tx_Serial.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; per-baud clocks-per-bit (CPB) = CLK_FREQ/baud, integer-truncated at elaboration.

Ports:
- internal_clock  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous active-low reset
- baud_rate_select  input  3  000=115200, 001=57600, 010=38400, 011=19200, 100=9600, 101..111=9600
- RX_Enable  input  1  active-high receive enable
- RX_Data  input  1  asynchronous serial line, idle high
- Rx_Byte  output  8  last correctly framed byte, held until next good frame
- Rx_Done  output  1  one-cycle pulse when Rx_Byte updates
- Rx_Active  output  1  high while a frame is being received (states START..STOP)
- Frame_Error  output  1  one-cycle pulse when the stop bit samples 0

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, Rx_Byte=8'h00, Rx_Done=0, Rx_Active=0, Frame_Error=0. Synchroniser and history registers are set to 1. All counters are cleared. Reset mid-frame aborts the frame with no output.
- Input path: 2-flop synchroniser on RX_Data gives rx_s. A 3-bit history of rx_s gives maj = majority of the last 3 values.
- CPB is latched from baud_rate_select at start detection. Changes to baud_rate_select mid-frame have no effect until the next frame.
- IDLE: detect a falling edge of rx_s (prev 1, now 0) while RX_Enable=1. On detection: latch CPB, cnt=0, go to START.
- START: cnt increments each clock. At cnt==CPB/2-1, test maj:
  - maj=0: go to DATA with cnt=0, bit_idx=0.
  - maj=1: glitch; return to IDLE with no outputs.
- DATA: cnt counts 0..CPB-1. At cnt==CPB-1:
  - shift maj into the data register LSB-first; cnt=0; bit_idx++.
  - after bit_idx 7 go to STOP.
- STOP: at cnt==CPB-1, test maj:
  - maj=1: Rx_Byte<=data register, Rx_Done=1 for exactly one cycle, go to IDLE.
  - maj=0: Frame_Error=1 for one cycle, Rx_Byte unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. A line held low (break) never retriggers start detection.
- RX_Enable=0 in any state forces IDLE next cycle. The frame is discarded and no strobe is issued. Rx_Byte holds its value.
- Latency: Rx_Done rises between 9.5*CPB and 9.5*CPB+5 clocks after the RX_Data falling edge of the start bit.
- Back-to-back: a start bit immediately following the stop bit (no extra idle) must be received, since IDLE is re-entered mid stop bit.
- Rx_Done and Frame_Error are never high in the same cycle. Neither is asserted outside the STOP→IDLE/WAIT_IDLE transition.
- Rx_Active is high in START, DATA and STOP only.

Test Plan:
- Reset check: reset_n=0 for 3 clocks with RX_Data toggling → Rx_Byte=00, Rx_Done=0, Rx_Active=0, Frame_Error=0 throughout.
- Good frames: select 000 (CPB=434), send 0xA5 from a bit-accurate driver → one Rx_Done pulse, Rx_Byte=A5, Frame_Error never high. Repeat at select 100 (CPB=5208) with 0x3C → Rx_Byte=3C, pulse 9.5*5208..+5 clocks after start edge.
- Glitch and noise: select 000, 100-clock low pulse on idle line → no Rx_Active past START, no Rx_Done. Then 0x55 with a 1-clock inverted spike at every bit centre → Rx_Byte=55 (majority vote).
- Framing error: select 000, send 0xF0 with stop bit 0, then hold the line low for 2000 clocks, then release → one Frame_Error pulse, Rx_Byte keeps its previous value, no new frame until the line returns high. Next frame 0x0F → Rx_Byte=0F.
- Enable/reset abort: drop RX_Enable during bit 4 of 0xAA → no Rx_Done, Rx_Byte unchanged. Then assert reset_n=0 during bit 2 of 0xBB → all outputs at reset values. Next 0x12 with both high → Rx_Byte=12.
- Back-to-back and baud change: select 001, stream 0x11, 0x22, 0x33 with zero idle between frames → three Rx_Done pulses with bytes 11, 22, 33 in order. Change baud_rate_select to 100 mid-frame of 0x22 → that frame is still received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: 2-flop synchroniser, 3-sample majority vote at mid-bit,
// start-glitch rejection, stop-bit framing check and break (line-low) lockout.
module uart_rx_frame #(
   parameter int CLK_FREQ = 50000000
) (
   input  logic       internal_clock,
   input  logic       reset_n,
   input  logic [2:0] baud_rate_select,
   input  logic       RX_Enable,
   input  logic       RX_Data,
   output logic [7:0] Rx_Byte,
   output logic       Rx_Done,
   output logic       Rx_Active,
   output logic       Frame_Error
);

   localparam int CPB_MAX = CLK_FREQ / 9600;
   localparam int CNT_W   = $clog2(CPB_MAX + 1);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_s_q;
   logic [2:0]       hist_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cpb_q, cpb_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             done_q, done_d;
   logic             ferr_q, ferr_d;
   logic             maj;
   logic [CNT_W-1:0] half_m1;

   function automatic logic maj3(input logic [2:0] h);
      return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
   endfunction

   function automatic logic [CNT_W-1:0] cpb_for(input logic [2:0] sel);
      logic [CNT_W-1:0] cpb;
      case (sel)
         3'b000:  cpb = CNT_W'(CLK_FREQ / 115200);
         3'b001:  cpb = CNT_W'(CLK_FREQ / 57600);
         3'b010:  cpb = CNT_W'(CLK_FREQ / 38400);
         3'b011:  cpb = CNT_W'(CLK_FREQ / 19200);
         default: cpb = CNT_W'(CLK_FREQ / 9600);
      endcase
      return cpb;
   endfunction

   assign maj     = maj3(hist_q);
   assign half_m1 = (cpb_q >> 1) - ONE;

   always_ff @(posedge internal_clock) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         hist_q    <= 3'b111;
         cnt_q     <= '0;
         cpb_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= RX_Data;
         rx_s_q    <= rx_meta_q;
         hist_q    <= {hist_q[1:0], rx_s_q};
         cnt_q     <= cnt_d;
         cpb_q     <= cpb_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   // hist_q[0] is rx_s one clock ago, so (hist_q[0] & ~rx_s_q) is the falling edge
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cpb_d     = cpb_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_d    = byte_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      if (!RX_Enable) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         bit_idx_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hist_q[0] && !rx_s_q) begin
                  cpb_d   = cpb_for(baud_rate_select);
                  cnt_d   = '0;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (cnt_q == half_m1) begin
                  cnt_d     = '0;
                  bit_idx_d = '0;
                  state_d   = maj ? S_IDLE : S_DATA;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            S_DATA: begin
               if (cnt_q == cpb_q - ONE) begin
                  shift_d   = {maj, shift_q[7:1]};
                  cnt_d     = '0;
                  bit_idx_d = bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_d = S_STOP;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            S_STOP: begin
               // Leaving mid stop bit lets a back-to-back start edge be caught
               if (cnt_q == cpb_q - ONE) begin
                  cnt_d = '0;
                  if (maj) begin
                     byte_d  = shift_q;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_WAIT_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
            S_WAIT_IDLE: begin
               if (rx_s_q) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign Rx_Byte     = byte_q;
   assign Rx_Done     = done_q;
   assign Frame_Error = ferr_q;
   assign Rx_Active   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule
